// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : enc_pkg
// Description : Shared types and helpers for the scan-style priority encoders.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  // Scan FSM state encoding: IDLE waits for a vector, SCAN drains it
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Ceiling log2, used at elaboration time to size index ports
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc_core.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_core
// Description : Combinational priority encoder. Reports the index of the
//               highest-priority set bit, whether any bit is set, and whether
//               exactly one bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_core #(
  parameter  int W         = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int IW        = enc_pkg::clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          one_o
);

  localparam logic [W-1:0] c_one = W'(1);

  generate
    if (MSB_FIRST) begin : g_msb_first
      // Ascending scan: the last set bit seen (the highest) wins
      always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
          if (vec_i[i]) idx_o = IW'(i);
        end
      end
    end else begin : g_lsb_first
      // Descending scan: the last set bit seen (the lowest) wins
      always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
          if (vec_i[i]) idx_o = IW'(i);
        end
      end
    end
  endgenerate

  // Single-bit test: clearing the lowest set bit leaves nothing behind
  assign any_o = |vec_i;
  assign one_o = any_o && ((vec_i & (vec_i - c_one)) == '0);

endmodule
`default_nettype wire

// File: rtl/priority_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_scan_encoder
// Description : Handshaked priority encoder that stores a request vector and
//               emits the index of every set bit, one per beat, in priority
//               order. An all-zero vector produces a single flagged beat.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_scan_encoder
  import enc_pkg::*;
#(
  parameter  int W         = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int IW        = clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_zero,
  output logic          busy
);

  localparam logic [W-1:0] c_one = W'(1);

  state_e        state_q;
  logic [W-1:0]  pend_q;
  logic [W-1:0]  pend_d;
  logic          zflag_q;

  logic [IW-1:0] w_idx;
  logic          w_any;
  logic          w_one;
  logic          w_scan;
  logic          w_last;

  prio_enc_core #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .vec_i (pend_q),
    .idx_o (w_idx),
    .any_o (w_any),
    .one_o (w_one)
  );

  assign w_scan = (state_q == ST_SCAN);

  // Final beat: zero vector, a single remaining bit, or (defensively) nothing left
  assign w_last = zflag_q | w_one | ~w_any;

  // Pending vector with the bit being emitted this beat removed
  assign pend_d = pend_q & ~(c_one << w_idx);

  // Accept in IDLE, or on the final beat's handshake for zero-bubble reload
  assign in_ready = ~abort & (~w_scan | (out_ready & w_last));

  assign out_valid = w_scan;
  assign busy      = w_scan;
  assign out_idx   = w_scan ? w_idx : '0;
  assign out_last  = w_scan & w_last;
  assign out_zero  = w_scan & zflag_q;

  // Scan FSM with pending-vector and zero-flag registers; reset beats abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zflag_q <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zflag_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_SCAN;
            pend_q  <= in_vec;
            zflag_q <= (in_vec == '0);
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            if (!w_last) begin
              pend_q <= pend_d;
            end else if (in_valid) begin
              pend_q  <= in_vec;
              zflag_q <= (in_vec == '0);
            end else begin
              state_q <= ST_IDLE;
              pend_q  <= '0;
              zflag_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pend_q  <= '0;
          zflag_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_scan_encoder
// Description : Scoreboard bench for priority_scan_encoder. Instance A is
//               W=8 MSB-first, instance B is W=16 LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_scan_encoder;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       abort_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic       out_last_a, out_zero_a, busy_a;
  logic [7:0] in_vec_a;
  logic [2:0] out_idx_a;

  logic        abort_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic        out_last_b, out_zero_b, busy_b;
  logic [15:0] in_vec_b;
  logic [3:0]  out_idx_b;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t qa[$];
  beat_t qb[$];
  bit    scan_a, scan_b, exp_ir_a, exp_ir_b;

  priority_scan_encoder #(.W(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .abort(abort_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_vec(in_vec_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_idx(out_idx_a),
    .out_last(out_last_a), .out_zero(out_zero_a), .busy(busy_a)
  );

  priority_scan_encoder #(.W(16), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .abort(abort_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_vec(in_vec_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_idx(out_idx_b),
    .out_last(out_last_b), .out_zero(out_zero_b), .busy(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: list the set bits in priority order, last one flagged
  function automatic void expect_vec(input bit side_b, input int w, input bit msb,
                                     input logic [15:0] v);
    int    left;
    int    b;
    beat_t bt;
    left = $countones(v);
    if (left == 0) begin
      bt = '{idx: 0, last: 1'b1, zero: 1'b1};
      if (side_b) qb.push_back(bt); else qa.push_back(bt);
      return;
    end
    for (int k = 0; k < w; k++) begin
      b = msb ? (w - 1 - k) : k;
      if (v[b]) begin
        left--;
        bt = '{idx: b, last: (left == 0), zero: 1'b0};
        if (side_b) qb.push_back(bt); else qa.push_back(bt);
      end
    end
  endfunction

  // Monitor A: compare presented beat with scoreboard head, then retire/enqueue
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
    end else begin
      scan_a   = (qa.size() != 0);
      exp_ir_a = !abort_a && (!scan_a || (out_ready_a && qa[0].last));
      chk("a_out_valid", out_valid_a, scan_a);
      chk("a_busy", busy_a, scan_a);
      chk("a_in_ready", in_ready_a, exp_ir_a);
      if (scan_a) begin
        chk("a_idx", out_idx_a, qa[0].idx);
        chk("a_last", out_last_a, qa[0].last);
        chk("a_zero", out_zero_a, qa[0].zero);
      end
      if (abort_a) begin
        qa.delete();
      end else begin
        if (scan_a && out_ready_a) void'(qa.pop_front());
        if (in_valid_a && exp_ir_a) expect_vec(1'b0, 8, 1'b1, {8'h00, in_vec_a});
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
    end else begin
      scan_b   = (qb.size() != 0);
      exp_ir_b = !abort_b && (!scan_b || (out_ready_b && qb[0].last));
      chk("b_out_valid", out_valid_b, scan_b);
      chk("b_busy", busy_b, scan_b);
      chk("b_in_ready", in_ready_b, exp_ir_b);
      if (scan_b) begin
        chk("b_idx", out_idx_b, qb[0].idx);
        chk("b_last", out_last_b, qb[0].last);
        chk("b_zero", out_zero_b, qb[0].zero);
      end
      if (abort_b) begin
        qb.delete();
      end else begin
        if (scan_b && out_ready_b) void'(qb.pop_front());
        if (in_valid_b && exp_ir_b) expect_vec(1'b1, 16, 1'b0, in_vec_b);
      end
    end
  end

  task automatic send_a(input logic [7:0] v);
    int t = 0;
    in_valid_a = 1'b1;
    in_vec_a   = v;
    @(negedge clk);
    while (!in_ready_a && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("a_accept_timeout", (t < 500), 1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_vec_a   = 8'($urandom);
  endtask

  task automatic send_b(input logic [15:0] v);
    int t = 0;
    in_valid_b = 1'b1;
    in_vec_b   = v;
    @(negedge clk);
    while (!in_ready_b && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("b_accept_timeout", (t < 500), 1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    in_vec_b   = 16'($urandom);
  endtask

  task automatic drain_a();
    int t = 0;
    @(posedge clk); #2;
    while ((qa.size() != 0 || out_valid_a) && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    chk("a_drain_timeout", (t < 500), 1);
  endtask

  task automatic drain_b();
    int t = 0;
    @(posedge clk); #2;
    while ((qb.size() != 0 || out_valid_b) && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    chk("b_drain_timeout", (t < 500), 1);
  endtask

  function automatic logic [15:0] rand_vec(input int w);
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = '0;
      1:       v = 16'(1) << $urandom_range(0, w - 1);
      default: v = 16'($urandom);
    endcase
    if (w == 8) v[15:8] = '0;
    return v;
  endfunction

  task automatic rand_a(input int n);
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) send_a(rand_vec(8)[7:0]);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready_a = ($urandom_range(0, 3) != 0);
          abort_a     = ($urandom_range(0, 31) == 0);
          @(posedge clk); #1;
        end
        abort_a     = 1'b0;
        out_ready_a = 1'b1;
      end
    join
    drain_a();
  endtask

  task automatic rand_b(input int n);
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) send_b(rand_vec(16));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready_b = ($urandom_range(0, 3) != 0);
          abort_b     = ($urandom_range(0, 31) == 0);
          @(posedge clk); #1;
        end
        abort_b     = 1'b0;
        out_ready_b = 1'b1;
      end
    join
    drain_b();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a full vector offered: nothing may be captured
    rst_n = 1'b0;
    abort_a = 1'b0; in_valid_a = 1'b1; in_vec_a = 8'hFF;    out_ready_a = 1'b1;
    abort_b = 1'b0; in_valid_b = 1'b1; in_vec_b = 16'hFFFF; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_idx", out_idx_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_out_zero", out_zero_a, 0);
    @(posedge clk); #1;

    // Drain 7,5,2
    send_a(8'b1010_0100);
    drain_a();

    // Backpressure: first beat held three cycles
    out_ready_a = 1'b0;
    send_a(8'b1010_0100);
    repeat (3) @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    drain_a();

    // Zero vector
    send_a(8'h00);
    drain_a();

    // Back-to-back 1,0,7 with no bubble
    send_a(8'h03);
    send_a(8'h80);
    drain_a();

    // Reset mid-scan discards the stored vector
    out_ready_a = 1'b0;
    send_a(8'h5A);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // LSB-first instance: abort on first beat, 15 never emitted
    out_ready_b = 1'b0;
    send_b(16'h8001);
    abort_b = 1'b1;
    @(posedge clk); #1;
    abort_b = 1'b0;
    @(negedge clk);
    chk("b_busy_after_abort", busy_b, 0);
    out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_b(16'h8000);
    @(negedge clk);
    chk("b_idx15", out_idx_b, 15);
    chk("b_idx15_last", out_last_b, 1);
    drain_b();

    // Randomised traffic with backpressure and aborts on both instances
    fork
      rand_a(80);
      rand_b(80);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
